// File: rtl/regset_write_arbiter.sv
// Two-port writeback arbiter in front of the regset write port.
// Round-robin (or fixed) grant, 1-cycle registered output stage, and a
// pending-write scoreboard for RAW hazard detection in issue.
module regset_write_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                       CLK,
  input  logic                       RES,
  input  logic                       req0_valid,
  input  logic [ADDR_WIDTH-1:0]      req0_addr,
  input  logic [DATA_WIDTH-1:0]      req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [ADDR_WIDTH-1:0]      req1_addr,
  input  logic [DATA_WIDTH-1:0]      req1_data,
  output logic                       req1_ready,
  input  logic                       claim_valid,
  input  logic [ADDR_WIDTH-1:0]      claim_addr,
  output logic [DATA_WIDTH-1:0]      D,
  output logic [ADDR_WIDTH-1:0]      A_D,
  output logic                       write_enable,
  output logic [2**ADDR_WIDTH-1:0]   busy
);

  logic                     last_grant;  // 1 = port 1 won the last transfer
  logic                     grant0, grant1, xfer;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [2**ADDR_WIDTH-1:0] busy_nxt;

  // Grant selection; nothing is accepted while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!RES) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRIORITY != 0 || last_grant) grant0 = 1'b1;
        else                                   grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign sel_addr   = grant0 ? req0_addr : req1_addr;
  assign sel_data   = grant0 ? req0_data : req1_data;

  // Output stage and round-robin pointer; writes to reg 0 are accepted
  // but never raise write_enable.
  always_ff @(posedge CLK) begin
    if (RES) begin
      last_grant   <= 1'b1;
      D            <= '0;
      A_D          <= '0;
      write_enable <= 1'b0;
    end else begin
      write_enable <= xfer && (sel_addr != '0);
      if (xfer) begin
        last_grant <= grant1;
        D          <= sel_data;
        A_D        <= sel_addr;
      end
    end
  end

  // Scoreboard next state: clear on commit first, so a same-edge claim wins.
  always_comb begin
    busy_nxt = busy;
    if (write_enable) busy_nxt[A_D] = 1'b0;
    if (claim_valid && claim_addr != '0) busy_nxt[claim_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge CLK) begin
    if (RES) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: tb/tb_regset_write_arbiter.sv
// Scoreboard bench: the driver's reference model pushes expected regset
// writes into a queue; a separate monitor pops them as write_enable appears.
module tb_regset_write_arbiter;
  logic        clk = 1'b0;
  logic        res;
  logic        v0, v1, cv;
  logic [4:0]  a0, a1, ca;
  logic [31:0] d0, d1;
  logic        r0, r1, we;
  logic [31:0] dq;
  logic [4:0]  ad;
  logic [31:0] busy;
  logic        fr0, fr1, fwe;
  logic [31:0] fdq, fbusy;
  logic [4:0]  fad;

  always #5 clk = ~clk;

  regset_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIORITY(0)) dut (
    .CLK(clk), .RES(res),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .claim_valid(cv), .claim_addr(ca),
    .D(dq), .A_D(ad), .write_enable(we), .busy(busy));

  regset_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIORITY(1)) u_fp (
    .CLK(clk), .RES(res),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(fr0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(fr1),
    .claim_valid(cv), .claim_addr(ca),
    .D(fdq), .A_D(fad), .write_enable(fwe), .busy(fbusy));

  typedef struct { logic [4:0] a; logic [31:0] d; int due; } wr_t;
  wr_t q[$];

  int checks = 0, errors = 0, cyc = 0;
  // reference model state
  int         prev_winner = 1;
  bit         reg_busy [32];
  bit         stg_v = 0;
  logic [4:0] stg_a = '0;
  bit         acc0, acc1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every regset write must match the oldest expected write, on time.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        cmp("wr_addr", ad, q[0].a);
        cmp("wr_data", dq, q[0].d);
        void'(q.pop_front());
      end else cmp("unexpected_write", {ad, dq}, 0);
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      cmp("missing_write", {1'b0, q[0].a}, {1'b1, q[0].a});
      void'(q.pop_front());
    end
  end

  // Compare this cycle's ready/busy with the model, then advance the model
  // to the state that follows the next clock edge.
  task automatic go();
    logic [31:0] bexp;
    @(negedge clk); #1;
    acc0 = 0; acc1 = 0;
    if (!res) begin
      if (v0 && v1) begin
        if (prev_winner == 1) acc0 = 1; else acc1 = 1;
      end else begin
        acc0 = v0; acc1 = v1;
      end
    end
    cmp("req0_ready", r0, acc0);
    cmp("req1_ready", r1, acc1);
    cmp("fp_req0_ready", fr0, !res && v0);
    cmp("fp_req1_ready", fr1, !res && v1 && !v0);
    bexp = '0;
    for (int i = 0; i < 32; i++) bexp[i] = reg_busy[i];
    cmp("busy", busy, bexp);
    if (res) begin
      prev_winner = 1; stg_v = 0; q.delete();
      for (int i = 0; i < 32; i++) reg_busy[i] = 0;
    end else begin
      if (stg_v) reg_busy[stg_a] = 0;
      if (cv && ca != 0) reg_busy[ca] = 1;
      stg_v = 0;
      if (acc0 || acc1) begin
        wr_t w;
        prev_winner = acc0 ? 0 : 1;
        w.a = acc0 ? a0 : a1;
        w.d = acc0 ? d0 : d1;
        w.due = cyc + 1;
        if (w.a != 0) begin
          q.push_back(w); stg_v = 1; stg_a = w.a;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    res = 0; v0 = 0; v1 = 0; cv = 0;
  endtask

  initial begin
    res = 1; v0 = 0; v1 = 0; cv = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; ca = 0;
    for (int i = 0; i < 32; i++) reg_busy[i] = 0;
    @(posedge clk); #1;
    go();
    // 1: reset with both requesters valid
    res = 1; v0 = 1; v1 = 1; a0 = 3; a1 = 4; d0 = 32'h11; d1 = 32'h22;
    go();
    idle();
    cmp("rst_we", we, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_D", dq, 0);
    cmp("rst_A_D", ad, 0);
    go();
    // 2: single write
    v0 = 1; a0 = 5; d0 = 32'hDEADBEEF;
    go();
    idle();
    cmp("single_we", we, 1);
    cmp("single_A_D", ad, 5);
    go(); go();
    // 3: sustained conflict, alternating grants, new data per acceptance
    v0 = 1; v1 = 1; a0 = 3; a1 = 4; d0 = 32'hA000; d1 = 32'hB000;
    for (int i = 0; i < 8; i++) begin
      go();
      if (acc0) d0 = d0 + 1;
      if (acc1) d1 = d1 + 1;
    end
    idle(); go(); go();
    // 4: zero register
    v1 = 1; a1 = 0; d1 = 32'h12345678;
    go();
    idle(); go(); go();
    // 5: scoreboard
    cv = 1; ca = 7; go();
    cv = 0; v0 = 1; a0 = 7; d0 = 32'h77; go();
    v0 = 0; cv = 1; ca = 7; go();     // commit edge with a new claim
    cv = 0; go();
    v0 = 1; a0 = 7; d0 = 32'h78; go();
    v0 = 0; go();
    cv = 1; ca = 0; go();
    idle(); go();
    // 6: reset right after a transfer
    cv = 1; ca = 9; go();
    cv = 0; v0 = 1; a0 = 9; d0 = 32'h99; go();
    v0 = 0; res = 1; go();
    res = 0;
    cmp("midrst_we", we, 0);
    cmp("midrst_busy", busy, 0);
    go(); go();
    // random traffic with hold-until-accepted requesters
    for (int n = 0; n < 3000; n++) begin
      res = ($urandom_range(0, 199) == 0);
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1; a0 = 5'($urandom_range(0, 7)); d0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1; a1 = 5'($urandom_range(0, 7)); d1 = $urandom;
      end
      cv = ($urandom_range(0, 2) == 0);
      ca = 5'($urandom_range(0, 7));
      go();
      if (acc0) v0 = 0;
      if (acc1) v1 = 0;
    end
    idle(); go(); go();
    cmp("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
